ifm_pair_streamer: RTL
======================

Name: ifm_pair_streamer

Overview:
- Transmit side of the pooling window FIFO interface.
- Reads one IFM channel (IFM_SIZE x IFM_SIZE pixels, raster order) from a synchronous single-cycle-latency dual-read feature RAM.
- Drives fifo_enable / fifo_data_in / fifo_data_in_2, two consecutive pixels per beat.
- Flags beats after which the downstream 2x2 window FIFO holds a full window; handshakes start/busy/done with the layer controller.

Parameters:
- DATA_WIDTH, 32, pixel width
- IFM_SIZE, 7, feature-map side length
- KERNAL_SIZE, 2, pooling window side
- ADDR_WIDTH, 6, feature-RAM address width
- FIFO_SIZE, (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE, downstream FIFO depth
- TOTAL_BEATS, (IFM_SIZE*IFM_SIZE+1)/2, beats per channel (25)
- FILL_BEATS, (FIFO_SIZE+1)/2, beats until the window is full (5)

Ports:
- clk, input, 1, clock
- reset, input, 1, asynchronous active-high reset
- start, input, 1, one-cycle request to stream a channel
- base_addr, input, ADDR_WIDTH, channel base address; latched on accepted start
- busy, output, 1, high from accepted start until done
- done, output, 1, one-cycle pulse after the final push
- rd_en, output, 1, RAM read strobe
- rd_addr_1, output, ADDR_WIDTH, address of the older pixel of the pair
- rd_addr_2, output, ADDR_WIDTH, rd_addr_1+1
- ram_data_1, input, DATA_WIDTH, data for rd_addr_1; valid the cycle after rd_en
- ram_data_2, input, DATA_WIDTH, data for rd_addr_2; valid the cycle after rd_en
- fifo_ready, input, 1, downstream may accept a push this cycle
- fifo_enable, output, 1, push strobe
- fifo_data_in, output, DATA_WIDTH, older pixel (ram_data_1)
- fifo_data_in_2, output, DATA_WIDTH, newer pixel (ram_data_2, or 0 when padded)
- window_valid, output, 1, pulse: the downstream window is complete after the preceding push

Behaviour:
- Reset (async, any state):
  - state=IDLE; beat counters=0; skid empty; rd_pending=0.
  - busy, done, rd_en, fifo_enable and window_valid are 0.
  - rd_addr_1, rd_addr_2, fifo_data_in and fifo_data_in_2 are 0.
  - A read in flight is discarded.
- FSM states:
  - IDLE -> RUN on start (latch base_addr; issue_cnt=0, push_cnt=0).
  - RUN -> DRAIN when issue_cnt reaches TOTAL_BEATS.
  - DRAIN -> DONE when push_cnt reaches TOTAL_BEATS.
  - DONE -> IDLE unconditionally.
  - start is ignored outside IDLE.
- busy is high in RUN, DRAIN and DONE. done is high only in DONE (exactly one cycle).
- Read issue (cycle t):
  - Condition: state=RUN, issue_cnt<TOTAL_BEATS, fifo_ready=1, skid empty.
  - rd_en=1; rd_addr_1=base+2*issue_cnt; rd_addr_2=rd_addr_1+1; issue_cnt++; rd_pending=1 for t+1.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - At most one read is in flight.
- Data return (cycle t+1):
  - fifo_ready=1: push directly. fifo_enable=1; outputs are the RAM data (combinational pass-through).
  - fifo_ready=0: capture the pair into the skid; fifo_enable=0.
- Skid occupied: no read is issued. The first cycle with fifo_ready=1 pushes the skid contents and empties the skid. The next read issues in the following cycle.
- Odd pixel count: on the last beat, if IFM_SIZE*IFM_SIZE is odd, fifo_data_in_2 is forced to 0. ram_data_2 is ignored for that beat.
- fifo_enable is never asserted while fifo_ready=0. There is exactly one push per beat; total pushes = TOTAL_BEATS.
- push_cnt increments on each push.
- window_valid is registered: high in the cycle after a push whose index (0-based) is >= FILL_BEATS-1.
- Throughput: with no stall, one beat per cycle. First push occurs 2 cycles after start; done occurs TOTAL_BEATS+2 cycles after start.
- A start in the same cycle as done is ignored; a new start is accepted from IDLE only.

Test Plan:
- Reset then start, base_addr=0, fifo_ready=1, RAM word n = n:
  - rd_addr_1 sequence 0,2,...,48; pushes (0,1),(2,3),...,(46,47),(48,0).
  - 25 fifo_enable pulses on consecutive cycles.
  - window_valid on pushes 5..25 (21 pulses); done 27 cycles after start.
- Stall: fifo_ready=0 for 3 cycles during beat 10 data return:
  - Pair (20,21) is held in the skid; no rd_en during the stall.
  - Pushed on the first ready cycle; next rd_addr_1=22 the cycle after; no beat lost or duplicated.
- fifo_ready held 0 at start: no rd_en and no fifo_enable; busy=1; the stream resumes when ready rises.
- base_addr=60 (ADDR_WIDTH=6): addresses 60,62,0,2,... wrap; rd_addr_2=61, 63, 1, ...
- Start asserted while busy, and asserted in the done cycle: ignored; exactly 25 pushes; one done pulse.
- Async reset asserted mid-RUN at beat 12: all outputs 0 immediately. A subsequent start streams from beat 0 with fresh counters.

Source files
------------

// File: rtl/ifm_pair_streamer_if.sv
// Push bus from the pixel-pair streamer into the pooling window FIFO.
// Two consecutive raster pixels travel per push.
interface ifm_pair_streamer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  fifo_ready;
   logic                  fifo_enable;
   logic [DATA_WIDTH-1:0] fifo_data_in;
   logic [DATA_WIDTH-1:0] fifo_data_in_2;
   logic                  window_valid;

   modport master (
      input  fifo_ready,
      output fifo_enable, fifo_data_in, fifo_data_in_2, window_valid
   );

   modport slave (
      output fifo_ready,
      input  fifo_enable, fifo_data_in, fifo_data_in_2, window_valid
   );
endinterface

// File: rtl/ifm_pair_streamer.sv
// Streams one IFM channel from a dual-read feature RAM into the
// pooling window FIFO, two pixels per beat, with a one-entry skid.
module ifm_pair_streamer #(
   parameter int DATA_WIDTH  = 32,
   parameter int IFM_SIZE    = 7,
   parameter int KERNAL_SIZE = 2,
   parameter int ADDR_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr_1,
   output logic [ADDR_WIDTH-1:0] rd_addr_2,
   input  logic [DATA_WIDTH-1:0] ram_data_1,
   input  logic [DATA_WIDTH-1:0] ram_data_2,
   ifm_pair_streamer_if.master   fifo
);
   localparam int FIFO_SIZE   = (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE;
   localparam int TOTAL_BEATS = (IFM_SIZE*IFM_SIZE+1)/2;
   localparam int FILL_BEATS  = (FIFO_SIZE+1)/2;
   localparam int CW          = $clog2(TOTAL_BEATS+1);
   localparam bit ODD         = ((IFM_SIZE*IFM_SIZE) % 2) == 1;
   localparam logic [CW-1:0] LAST = CW'(TOTAL_BEATS-1);
   localparam logic [CW-1:0] FULL = CW'(FILL_BEATS-1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] base;
   logic [CW-1:0]         issue_cnt;
   logic [CW-1:0]         push_cnt;
   logic                  rd_pending;
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_1;
   logic [DATA_WIDTH-1:0] skid_2;
   logic                  push_ram;
   logic                  push_skid;
   logic                  push;
   logic                  pad;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] d1;
   logic [DATA_WIDTH-1:0] d2;

   assign rd_en = (state == RUN) && (issue_cnt != CW'(TOTAL_BEATS))
                  && fifo.fifo_ready && !skid_valid;
   assign addr      = base + ADDR_WIDTH'({issue_cnt, 1'b0});
   assign rd_addr_1 = rd_en ? addr : '0;
   assign rd_addr_2 = rd_en ? addr + ADDR_WIDTH'(1) : '0;

   assign push_ram  = rd_pending && fifo.fifo_ready;
   assign push_skid = skid_valid && fifo.fifo_ready;
   assign push      = push_ram || push_skid;
   // Odd pixel count: the final pair has no real second pixel.
   assign pad       = ODD && (push_cnt == LAST);

   always_comb begin
      d1 = '0;
      d2 = '0;
      if (push_skid) begin
         d1 = skid_1;
         d2 = skid_2;
      end else if (push_ram) begin
         d1 = ram_data_1;
         d2 = ram_data_2;
      end
      if (pad) d2 = '0;
   end

   assign fifo.fifo_enable    = push;
   assign fifo.fifo_data_in   = d1;
   assign fifo.fifo_data_in_2 = d2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         base              <= '0;
         issue_cnt         <= '0;
         push_cnt          <= '0;
         rd_pending        <= 1'b0;
         skid_valid        <= 1'b0;
         skid_1            <= '0;
         skid_2            <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         fifo.window_valid <= 1'b0;
      end else begin
         rd_pending        <= rd_en;
         fifo.window_valid <= push && (push_cnt >= FULL);
         if (rd_pending && !fifo.fifo_ready) begin
            skid_valid <= 1'b1;
            skid_1     <= ram_data_1;
            skid_2     <= ram_data_2;
         end else if (push_skid) begin
            skid_valid <= 1'b0;
         end
         if (push) push_cnt <= push_cnt + CW'(1);
         unique case (state)
            IDLE: begin
               if (start) begin
                  base      <= base_addr;
                  issue_cnt <= '0;
                  push_cnt  <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (rd_en) begin
                  issue_cnt <= issue_cnt + CW'(1);
                  if (issue_cnt == LAST) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (push && push_cnt == LAST) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
